// File: rtl/lsu_dmem_master.sv
// Load/store unit master for a single-ported data memory.
// Range and alignment checks run at accept; loads get lane select and extension.
module lsu_dmem_master #(
   parameter logic [31:0] BASE_ADDR   = 32'h10010000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] resp_badaddr,
   output logic        mem_ena,
   output logic        mem_wena,
   output logic [1:0]  mem_w_cs,
   output logic [1:0]  mem_r_cs,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0]  SZ_WORD  = 2'b01;
   localparam logic [1:0]  SZ_HALF  = 2'b10;
   localparam logic [1:0]  SZ_BYTE  = 2'b11;
   localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH_WORDS);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] badaddr_q, badaddr_d;

   logic        accept;
   logic [31:0] offset;
   logic        range_err;
   logic        align_err;
   logic        req_err;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_data;
   logic [31:0] store_data;
   logic        last_access;

   assign accept      = req_valid && req_ready;
   assign last_access = (state_q == ACCESS) && (cnt_q == 4'd0);

   // The below-base test comes first so a wrapped offset is never trusted.
   always_comb begin
      offset    = req_addr - BASE_ADDR;
      range_err = (req_addr < BASE_ADDR) || ((offset >> 2) >= DEPTH_W);
      align_err = (req_size == 2'b00)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
      req_err   = range_err || align_err;
   end

   always_comb begin
      lane_byte = 8'h00;
      case (addr_q[1:0])
         2'd0:    lane_byte = mem_rdata[7:0];
         2'd1:    lane_byte = mem_rdata[15:8];
         2'd2:    lane_byte = mem_rdata[23:16];
         default: lane_byte = mem_rdata[31:24];
      endcase
      lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         SZ_BYTE: load_data = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
         SZ_HALF: load_data = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
         default: load_data = mem_rdata;
      endcase
   end

   // Store data leaves right-aligned; the memory places it by mem_w_cs and mem_addr.
   always_comb begin
      case (size_q)
         SZ_BYTE: store_data = {24'h0, wdata_q[7:0]};
         SZ_HALF: store_data = {16'h0, wdata_q[15:0]};
         default: store_data = wdata_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         signed_q  <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
         badaddr_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         size_q    <= size_d;
         signed_q  <= signed_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         badaddr_q <= badaddr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      size_d    = size_q;
      signed_d  = signed_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      badaddr_d = badaddr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d      = req_we;
               size_d    = req_size;
               signed_d  = req_signed;
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               rdata_d   = 32'h0;
               if (req_err) begin
                  state_d   = RESP;
                  err_d     = 1'b1;
                  badaddr_d = req_addr;
               end else begin
                  state_d   = ACCESS;
                  cnt_d     = CNT_LOAD;
                  err_d     = 1'b0;
                  badaddr_d = 32'h0;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               rdata_d = we_q ? 32'h0 : load_data;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready    = (state_q == IDLE) && !rst;
      resp_valid   = (state_q == RESP);
      resp_rdata   = resp_valid ? rdata_q : 32'h0;
      resp_err     = resp_valid ? err_q : 1'b0;
      resp_badaddr = resp_valid ? badaddr_q : 32'h0;
      mem_ena      = 1'b0;
      mem_wena     = 1'b0;
      mem_w_cs     = 2'b00;
      mem_r_cs     = 2'b00;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      if (state_q == ACCESS) begin
         mem_ena   = 1'b1;
         mem_wena  = we_q && last_access;
         mem_w_cs  = size_q;
         mem_r_cs  = SZ_WORD;
         mem_addr  = addr_q;
         mem_wdata = we_q ? store_data : 32'h0;
      end
   end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: one instance with WAIT_CYCLES=1 (A), one with 3 (B),
// each backed by a byte-lane memory model.
module tb_lsu_dmem_master;

   localparam logic [31:0] BASE = 32'h10010000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;

   logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_req_signed = 1'b0, a_resp_ready = 1'b1;
   logic [1:0]  a_req_size = 2'b01;
   logic [31:0] a_req_addr = 32'h0, a_req_wdata = 32'h0;
   logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_ena, a_mem_wena;
   logic [31:0] a_resp_rdata, a_resp_badaddr, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [1:0]  a_mem_w_cs, a_mem_r_cs;

   logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_req_signed = 1'b0, b_resp_ready = 1'b1;
   logic [1:0]  b_req_size = 2'b01;
   logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0;
   logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_ena, b_mem_wena;
   logic [31:0] b_resp_rdata, b_resp_badaddr, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [1:0]  b_mem_w_cs, b_mem_r_cs;

   logic [31:0] memA [0:1023];
   logic [31:0] memB [0:1023];
   logic [9:0]  a_idx, b_idx;
   int          a_wrCount = 0;
   int          b_wrCount = 0;

   always #5 clk = ~clk;

   lsu_dmem_master #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we), .req_size(a_req_size),
      .req_signed(a_req_signed), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
      .resp_err(a_resp_err), .resp_badaddr(a_resp_badaddr),
      .mem_ena(a_mem_ena), .mem_wena(a_mem_wena), .mem_w_cs(a_mem_w_cs), .mem_r_cs(a_mem_r_cs),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
   );

   lsu_dmem_master #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_size(b_req_size),
      .req_signed(b_req_signed), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
      .resp_err(b_resp_err), .resp_badaddr(b_resp_badaddr),
      .mem_ena(b_mem_ena), .mem_wena(b_mem_wena), .mem_w_cs(b_mem_w_cs), .mem_r_cs(b_mem_r_cs),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   assign a_idx = 10'((a_mem_addr - BASE) >> 2);
   assign b_idx = 10'((b_mem_addr - BASE) >> 2);
   assign a_mem_rdata = memA[a_idx];
   assign b_mem_rdata = memB[b_idx];

   // Memory model: right-aligned write data is placed into the lane chosen by cs and addr.
   always @(posedge clk) begin
      if (a_mem_wena) begin
         a_wrCount <= a_wrCount + 1;
         case (a_mem_w_cs)
            2'b01:   memA[a_idx] <= a_mem_wdata;
            2'b10:   memA[a_idx][16*a_mem_addr[1] +: 16] <= a_mem_wdata[15:0];
            2'b11:   memA[a_idx][8*a_mem_addr[1:0] +: 8] <= a_mem_wdata[7:0];
            default: ;
         endcase
      end
      if (b_mem_wena) begin
         b_wrCount <= b_wrCount + 1;
         case (b_mem_w_cs)
            2'b01:   memB[b_idx] <= b_mem_wdata;
            2'b10:   memB[b_idx][16*b_mem_addr[1] +: 16] <= b_mem_wdata[15:0];
            2'b11:   memB[b_idx][8*b_mem_addr[1:0] +: 8] <= b_mem_wdata[7:0];
            default: ;
         endcase
      end
   end

   // Issue one request on A and wait (bounded) for its response; lat=-1 on timeout.
   task automatic runA(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output logic [31:0] bad, output int lat, output int ena);
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = we; a_req_size = sz; a_req_signed = sg;
      a_req_addr = ad; a_req_wdata = wd;
      lat = 0; ena = 0;
      do begin
         @(negedge clk);
         a_req_valid = 1'b0;
         lat++;
         if (a_mem_ena) ena++;
      end while (!a_resp_valid && lat < 40);
      rd = a_resp_rdata; er = a_resp_err; bad = a_resp_badaddr;
      if (!a_resp_valid) lat = -1;
      @(negedge clk);
   endtask

   task automatic runB(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                       input logic [31:0] wd, output logic er, output int lat);
      @(negedge clk);
      b_req_valid = 1'b1; b_req_we = we; b_req_size = sz; b_req_signed = 1'b0;
      b_req_addr = ad; b_req_wdata = wd;
      lat = 0;
      do begin
         @(negedge clk);
         b_req_valid = 1'b0;
         lat++;
      end while (!b_resp_valid && lat < 40);
      er = b_resp_err;
      if (!b_resp_valid) lat = -1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++; if (a_req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_req_ready got %b expected 0", a_req_ready); end
      tests_run++; if ({a_resp_valid, a_mem_ena, a_mem_wena, b_resp_valid, b_mem_ena} !== 5'b0) begin tests_failed++; $display("[TB] FAIL rst_outputs got %b expected 00000", {a_resp_valid, a_mem_ena, a_mem_wena, b_resp_valid, b_mem_ena}); end
      tests_run++; if ({a_resp_rdata, a_mem_addr, a_mem_wdata} !== 96'h0) begin tests_failed++; $display("[TB] FAIL rst_data got %h expected 0", {a_resp_rdata, a_mem_addr, a_mem_wdata}); end
      rst = 1'b0;
      @(negedge clk);
      tests_run++; if ({a_req_ready, b_req_ready} !== 2'b11) begin tests_failed++; $display("[TB] FAIL rst_release_ready got %b expected 11", {a_req_ready, b_req_ready}); end
   endtask

   task automatic test_word_store();
      int w0;
      w0 = a_wrCount;
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'b01; a_req_signed = 1'b0;
      a_req_addr = 32'h10010004; a_req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      a_req_valid = 1'b0;
      tests_run++; if ({a_mem_ena, a_mem_wena, a_mem_w_cs, a_mem_r_cs} !== 6'b11_01_01) begin tests_failed++; $display("[TB] FAIL ws_mem_ctrl got %b expected 110101", {a_mem_ena, a_mem_wena, a_mem_w_cs, a_mem_r_cs}); end
      tests_run++; if (a_mem_addr !== 32'h10010004) begin tests_failed++; $display("[TB] FAIL ws_mem_addr got %h expected 10010004", a_mem_addr); end
      tests_run++; if (a_mem_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL ws_mem_wdata got %h expected deadbeef", a_mem_wdata); end
      tests_run++; if ({a_resp_valid, a_req_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL ws_access_hs got %b expected 00", {a_resp_valid, a_req_ready}); end
      @(negedge clk);
      tests_run++; if ({a_resp_valid, a_resp_err, a_mem_ena} !== 3'b100) begin tests_failed++; $display("[TB] FAIL ws_resp got %b expected 100", {a_resp_valid, a_resp_err, a_mem_ena}); end
      tests_run++; if (a_resp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL ws_resp_rdata got %h expected 0", a_resp_rdata); end
      tests_run++; if (memA[1] !== 32'hDEADBEEF || a_wrCount !== w0 + 1) begin tests_failed++; $display("[TB] FAIL ws_memory got %h writes %0d expected deadbeef writes %0d", memA[1], a_wrCount - w0, 1); end
      @(negedge clk);
      tests_run++; if ({a_resp_valid, a_req_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL ws_return_idle got %b expected 01", {a_resp_valid, a_req_ready}); end
   endtask

   task automatic test_loads();
      logic [31:0] rd, bad; logic er; int lat, ena;
      runA(1'b1, 2'b01, 1'b0, 32'h10010008, 32'h80F07F01, rd, er, bad, lat, ena);
      runA(1'b0, 2'b11, 1'b1, 32'h1001000B, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin tests_failed++; $display("[TB] FAIL ld_sbyte got %h err %b expected ffffff80 err 0", rd, er); end
      tests_run++; if (lat !== 2 || ena !== 1) begin tests_failed++; $display("[TB] FAIL ld_latency got lat %0d ena %0d expected lat 2 ena 1", lat, ena); end
      runA(1'b0, 2'b11, 1'b0, 32'h1001000B, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (rd !== 32'h00000080) begin tests_failed++; $display("[TB] FAIL ld_ubyte got %h expected 00000080", rd); end
      runA(1'b0, 2'b10, 1'b1, 32'h1001000A, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (rd !== 32'hFFFF80F0) begin tests_failed++; $display("[TB] FAIL ld_shalf got %h expected ffff80f0", rd); end
      runA(1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (rd !== 32'h00007F01) begin tests_failed++; $display("[TB] FAIL ld_uhalf_lo got %h expected 00007f01", rd); end
      runA(1'b0, 2'b11, 1'b1, 32'h10010009, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (rd !== 32'h0000007F) begin tests_failed++; $display("[TB] FAIL ld_sbyte_pos got %h expected 0000007f", rd); end
      runA(1'b0, 2'b01, 1'b1, 32'h10010008, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (rd !== 32'h80F07F01) begin tests_failed++; $display("[TB] FAIL ld_word got %h expected 80f07f01", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd, bad; logic er; int lat, ena;
      runA(1'b0, 2'b01, 1'b0, 32'h10010002, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if ({er, rd, bad} !== {1'b1, 32'h0, 32'h10010002}) begin tests_failed++; $display("[TB] FAIL err_misalign got err %b rdata %h bad %h expected 1 0 10010002", er, rd, bad); end
      tests_run++; if (lat !== 1 || ena !== 0) begin tests_failed++; $display("[TB] FAIL err_latency got lat %0d ena %0d expected lat 1 ena 0", lat, ena); end
      runA(1'b0, 2'b01, 1'b0, 32'h1000FFFC, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (er !== 1'b1 || bad !== 32'h1000FFFC) begin tests_failed++; $display("[TB] FAIL err_below got err %b bad %h expected 1 1000fffc", er, bad); end
      runA(1'b1, 2'b01, 1'b0, 32'h10011000, 32'h1, rd, er, bad, lat, ena);
      tests_run++; if (er !== 1'b1 || ena !== 0) begin tests_failed++; $display("[TB] FAIL err_above got err %b ena %0d expected 1 0", er, ena); end
      runA(1'b0, 2'b01, 1'b0, 32'h10010FFC, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (er !== 1'b0 || lat !== 2) begin tests_failed++; $display("[TB] FAIL err_last_word got err %b lat %0d expected 0 2", er, lat); end
      runA(1'b0, 2'b00, 1'b0, 32'h10010000, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_size00 got %b expected 1", er); end
      runA(1'b0, 2'b10, 1'b0, 32'h10010001, 32'h0, rd, er, bad, lat, ena);
      tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_half_odd got %b expected 1", er); end
   endtask

   task automatic test_wait3_store();
      logic er; int lat, n, enaCnt, wenaCnt, wenaAt, bad, w0;
      runB(1'b1, 2'b01, 32'h10010000, 32'h11223344, er, lat);
      w0 = b_wrCount; n = 0; enaCnt = 0; wenaCnt = 0; wenaAt = 0; bad = 0;
      @(negedge clk);
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'b11; b_req_addr = 32'h10010001; b_req_wdata = 32'h000000AB;
      do begin
         @(negedge clk);
         b_req_valid = 1'b0;
         n++;
         if (b_mem_ena) begin
            enaCnt++;
            if (b_mem_wena) begin wenaCnt++; wenaAt = enaCnt; end
            if (b_mem_wdata !== 32'h000000AB || b_mem_w_cs !== 2'b11 || b_mem_r_cs !== 2'b01 || b_mem_addr !== 32'h10010001) bad++;
         end
      end while (!b_resp_valid && n < 40);
      tests_run++; if (enaCnt !== 3) begin tests_failed++; $display("[TB] FAIL w3_ena_cycles got %0d expected 3", enaCnt); end
      tests_run++; if (wenaCnt !== 1 || wenaAt !== 3) begin tests_failed++; $display("[TB] FAIL w3_wena got count %0d at %0d expected count 1 at 3", wenaCnt, wenaAt); end
      tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL w3_mem_bus got %0d bad cycles expected 0", bad); end
      tests_run++; if (n !== 4 || b_resp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL w3_resp got lat %0d err %b expected 4 0", n, b_resp_err); end
      @(negedge clk);
      tests_run++; if (memB[0] !== 32'h1122AB44 || b_wrCount !== w0 + 1) begin tests_failed++; $display("[TB] FAIL w3_memory got %h writes %0d expected 1122ab44 writes 1", memB[0], b_wrCount - w0); end
   endtask

   task automatic test_backpressure();
      int n, w0;
      w0 = a_wrCount; n = 0;
      a_resp_ready = 1'b0;
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'b01; a_req_signed = 1'b0; a_req_addr = 32'h10010004;
      do begin
         @(negedge clk);
         a_req_valid = 1'b0;
         n++;
      end while (!a_resp_valid && n < 40);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h1001000C; a_req_wdata = 32'h55555555;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++; if (a_resp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_valid_%0d got %b expected 1", i, a_resp_valid); end
         tests_run++; if (a_resp_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL bp_rdata_%0d got %h expected deadbeef", i, a_resp_rdata); end
         tests_run++; if (a_req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready_%0d got %b expected 0", i, a_req_ready); end
      end
      a_req_valid = 1'b0; a_resp_ready = 1'b1;
      @(negedge clk);
      tests_run++; if ({a_resp_valid, a_req_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL bp_release got %b expected 01", {a_resp_valid, a_req_ready}); end
      @(negedge clk);
      tests_run++; if (a_mem_ena !== 1'b0 || a_wrCount !== w0) begin tests_failed++; $display("[TB] FAIL bp_ignored_req got ena %b writes %0d expected 0 0", a_mem_ena, a_wrCount - w0); end
   endtask

   task automatic test_back_to_back();
      int n;
      n = 0;
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'b01; a_req_signed = 1'b0; a_req_addr = 32'h10010008;
      do begin
         @(negedge clk);
         n++;
      end while (!a_resp_valid && n < 40);
      tests_run++; if (a_resp_rdata !== 32'h80F07F01 || n !== 2) begin tests_failed++; $display("[TB] FAIL b2b_first got %h lat %0d expected 80f07f01 lat 2", a_resp_rdata, n); end
      a_req_addr = 32'h10010004;
      @(negedge clk);
      tests_run++; if ({a_resp_valid, a_req_ready, a_mem_ena} !== 3'b010) begin tests_failed++; $display("[TB] FAIL b2b_one_resp_cycle got %b expected 010", {a_resp_valid, a_req_ready, a_mem_ena}); end
      @(negedge clk);
      a_req_valid = 1'b0;
      tests_run++; if (a_mem_ena !== 1'b1 || a_mem_addr !== 32'h10010004) begin tests_failed++; $display("[TB] FAIL b2b_second_access got ena %b addr %h expected 1 10010004", a_mem_ena, a_mem_addr); end
      @(negedge clk);
      tests_run++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL b2b_second got valid %b rdata %h expected 1 deadbeef", a_resp_valid, a_resp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      logic er; int lat, w0, seen;
      runB(1'b1, 2'b01, 32'h10010010, 32'hCAFEF00D, er, lat);
      w0 = b_wrCount; seen = 0;
      @(negedge clk);
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'b01; b_req_addr = 32'h10010010; b_req_wdata = 32'h12345678;
      @(negedge clk);
      b_req_valid = 1'b0;
      @(negedge clk);
      tests_run++; if (b_mem_ena !== 1'b1 || b_mem_wena !== 1'b0) begin tests_failed++; $display("[TB] FAIL ab_second_access got ena %b wena %b expected 1 0", b_mem_ena, b_mem_wena); end
      rst = 1'b1;
      #1;
      tests_run++; if ({b_mem_ena, b_mem_wena, b_req_ready} !== 3'b000) begin tests_failed++; $display("[TB] FAIL ab_async_drop got %b expected 000", {b_mem_ena, b_mem_wena, b_req_ready}); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (b_resp_valid) seen++;
      end
      tests_run++; if (seen !== 0) begin tests_failed++; $display("[TB] FAIL ab_no_resp got %0d valid cycles expected 0", seen); end
      tests_run++; if (b_wrCount !== w0 || memB[4] !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL ab_memory got %h writes %0d expected cafef00d writes 0", memB[4], b_wrCount - w0); end
      tests_run++; if (b_req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ab_ready got %b expected 1", b_req_ready); end
   endtask

   task automatic test_reset_resp();
      int n, seen;
      n = 0; seen = 0;
      a_resp_ready = 1'b0;
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'b01; a_req_addr = 32'h10010004;
      do begin
         @(negedge clk);
         a_req_valid = 1'b0;
         n++;
      end while (!a_resp_valid && n < 40);
      tests_run++; if (a_resp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_pending got %b expected 1", a_resp_valid); end
      rst = 1'b1;
      #1;
      tests_run++; if (a_resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_drop got %b expected 0", a_resp_valid); end
      @(negedge clk);
      rst = 1'b0; a_resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (a_resp_valid) seen++;
      end
      tests_run++; if (seen !== 0 || a_req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_discarded got %0d valid cycles ready %b expected 0 1", seen, a_req_ready); end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_loads();
      test_errors();
      test_wait3_store();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_reset_resp();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/lsu_dmem_master.md
LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10010000, data memory base byte address.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, data memory size in 32-bit words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1 (legal 1..15), memory access cycles per request.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset.
REQ-005 One clock; reset is asynchronous and active-high, ports named clk and rst.
REQ-006 SHALL have pipeline-side ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_size in 2 (01 word, 10 half, 11 byte); req_signed in 1 (load sign-extend); req_addr in 32; req_wdata in 32.
REQ-007 SHALL have response ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32; resp_err out 1; resp_badaddr out 32.
REQ-008 SHALL have memory-side ports: mem_ena out 1; mem_wena out 1; mem_w_cs out 2; mem_r_cs out 2; mem_addr out 32; mem_wdata out 32; mem_rdata in 32 (combinational read of the addressed word).

Function
REQ-009 FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-010 Accept when req_valid && req_ready at a rising edge; latch we, size, signed, addr, wdata.
REQ-011 Error check at accept: offset=addr-BASE_ADDR; error if addr<BASE_ADDR, offset/4>=DEPTH_WORDS, req_size=00, half with addr[0]=1, or word with addr[1:0]!=0.
REQ-012 On error: go directly to RESP with resp_err=1, resp_badaddr=addr, resp_rdata=0; no mem_ena assertion.
REQ-013 On no error: go to ACCESS; counter loaded with WAIT_CYCLES-1, decremented each cycle; leave ACCESS when counter=0.
REQ-014 In ACCESS: mem_ena=1, mem_addr=latched addr, mem_r_cs=01 (always word read), mem_w_cs=latched size.
REQ-015 mem_wena SHALL be 1 only in the final ACCESS cycle of a store, giving exactly one memory write edge per store.
REQ-016 Store data: mem_wdata=wdata for word; {16'b0,wdata[15:0]} for half; {24'b0,wdata[7:0]} for byte.
REQ-017 Load: in final ACCESS cycle sample mem_rdata; select byte lane addr[1:0] (byte) or half lane addr[1] (half); sign- or zero-extend per latched signed; word passes unchanged.
REQ-018 RESP: resp_valid=1, resp_rdata/resp_err/resp_badaddr held stable until resp_valid && resp_ready; then IDLE.
REQ-019 Store response: resp_rdata=0, resp_err=0.
REQ-020 Latency: accept at edge N; resp_valid high from edge N+WAIT_CYCLES (error: N+1) until handshake.
REQ-021 Outside ACCESS: mem_ena=0, mem_wena=0, mem_w_cs=00, mem_r_cs=00, mem_addr=0, mem_wdata=0.
REQ-022 resp_ready asserted in the cycle resp_valid rises SHALL complete in one RESP cycle; back-to-back request accepted in following IDLE cycle.
REQ-023 Request inputs SHALL be ignored outside IDLE.
REQ-024 Address arithmetic 32-bit unsigned; wrap below BASE_ADDR flagged as error, not wrapped.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, counter=0, all outputs 0 except req_ready, which is 0 while rst=1 and 1 from first cycle after release.
REQ-026 Reset during ACCESS SHALL drop mem_ena/mem_wena asynchronously; no memory write occurs at any edge while rst=1; aborted request produces no response.
REQ-027 Reset during RESP SHALL discard the pending response.

Verification
REQ-028 Word store addr 10010004, wdata DEADBEEF, WAIT_CYCLES=1 -> one edge with mem_wena=1, mem_w_cs=01, mem_addr=10010004; resp_valid next cycle, resp_err=0.
REQ-029 Preload word 0x80F07F01 at 10010008; signed byte load 1001000B -> resp_rdata=FFFFFF80; unsigned -> 00000080; signed half 1001000A -> FFFF80F0.
REQ-030 Word load 10010002 -> no mem_ena, resp_err=1, resp_badaddr=10010002; addr 1000FFFC and 10011000 -> resp_err=1.
REQ-031 WAIT_CYCLES=3 byte store 10010001 data 000000AB -> mem_ena high 3 cycles, mem_wena only in third, mem_wdata=000000AB, mem_w_cs=11.
REQ-032 Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0; new req_valid ignored until handshake.
REQ-033 Assert rst in second ACCESS cycle of WAIT_CYCLES=3 store -> mem_wena never 1, memory unchanged, no resp_valid, req_ready=1 after release.
